// File: rtl/avr_cmd_seq.sv
// avr_cmd_seq: decodes AVR command strobes and runs clock-timed SRAM read/write cycles.
// Strobes are decoded from a registered FSM, so setup and hold come from the clock rather than the AVR's pins.
module avr_cmd_seq #(
  parameter int ADDR_W   = 21,
  parameter int DATA_W   = 8,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        cmd,
  input  logic              cmd_stb,
  input  logic              si,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dout,
  input  logic [DATA_W-1:0] sram_din,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam logic [2:0] CMD_SHIFT     = 3'd1;
  localparam logic [2:0] CMD_READ      = 3'd2;
  localparam logic [2:0] CMD_WRITE     = 3'd3;
  localparam logic [2:0] CMD_READ_INC  = 3'd4;
  localparam logic [2:0] CMD_WRITE_INC = 3'd5;
  localparam logic [2:0] CMD_CLR_ADDR  = 3'd6;
  localparam logic [3:0] WAIT_LAST     = 4'(WAIT_CYC);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [3:0]        r_waitCnt;
  logic              r_isWrite;
  logic              r_isInc;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_dout;
  logic              w_accept;
  logic              w_startCycle;
  logic              w_startWrite;
  logic              w_lastStrobe;

  assign w_accept     = cmd_stb && (r_state == S_IDLE);
  assign w_startCycle = w_accept && (cmd inside {CMD_READ, CMD_WRITE, CMD_READ_INC, CMD_WRITE_INC});
  assign w_startWrite = (cmd == CMD_WRITE) || (cmd == CMD_WRITE_INC);
  assign w_lastStrobe = (r_state == S_STROBE) && (r_waitCnt == WAIT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:   if (w_startCycle) w_nextState = S_SETUP;
      S_SETUP:  w_nextState = S_STROBE;
      S_STROBE: if (w_lastStrobe) w_nextState = S_HOLD;
      S_HOLD:   w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
  end

  // Reads never enable the data driver, so oe_n low and dq_oe high cannot coincide.
  always_comb begin
    busy       = 1'b0;
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_dq_oe = 1'b0;
    case (r_state)
      S_SETUP: begin
        busy       = 1'b1;
        sram_ce_n  = 1'b0;
        sram_dq_oe = r_isWrite;
      end
      S_STROBE: begin
        busy       = 1'b1;
        sram_ce_n  = 1'b0;
        sram_oe_n  = r_isWrite;
        sram_we_n  = !r_isWrite;
        sram_dq_oe = r_isWrite;
      end
      S_HOLD: begin
        busy       = 1'b1;
        sram_dq_oe = r_isWrite;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_waitCnt <= 4'd0;
    end else if (r_state == S_STROBE) begin
      r_waitCnt <= r_waitCnt + 4'd1;
    end else begin
      r_waitCnt <= 4'd0;
    end
  end

  // Cycle attributes are captured once at accept and held until the next accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_isWrite <= 1'b0;
      r_isInc   <= 1'b0;
      r_dout    <= '0;
      r_rdata   <= '0;
      r_addr    <= '0;
    end else begin
      if (w_startCycle) begin
        r_isWrite <= w_startWrite;
        r_isInc   <= (cmd == CMD_READ_INC) || (cmd == CMD_WRITE_INC);
        if (w_startWrite) r_dout <= wdata;
      end
      if (w_lastStrobe && !r_isWrite) r_rdata <= sram_din;
      if (w_accept && (cmd == CMD_SHIFT)) begin
        r_addr <= {r_addr[ADDR_W-2:0], si};
      end else if (w_accept && (cmd == CMD_CLR_ADDR)) begin
        r_addr <= '0;
      end else if ((r_state == S_HOLD) && r_isInc) begin
        r_addr <= r_addr + ADDR_W'(1);
      end
    end
  end

  assign sram_addr = r_addr;
  assign sram_dout = r_dout;
  assign rdata     = r_rdata;

endmodule

// File: tb/tb_avr_cmd_seq.sv
// tb_avr_cmd_seq: directed scenarios plus randomized traffic for avr_cmd_seq.
// The reference model tracks each access by its cycle index since the accepting edge.
module tb_avr_cmd_seq;

  localparam int AW = 21;
  localparam int DW = 8;
  localparam int W  = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    cmd = 3'd0;
  logic          cmd_stb = 1'b0;
  logic          si = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] sram_din = '0;
  logic [DW-1:0] rdata;
  logic          busy;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dout;
  logic          sram_dq_oe;
  logic          sram_ce_n;
  logic          sram_oe_n;
  logic          sram_we_n;
  logic [4:0]    ctl;

  int nChecks = 0;
  int nErrors = 0;

  logic [AW-1:0] mAddr;
  logic [DW-1:0] mRdata;
  logic [DW-1:0] mDout;
  int            opK;
  bit            opWrite;
  bit            opInc;

  avr_cmd_seq #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(W)) dut (
    .clk(clk), .reset_n(reset_n), .cmd(cmd), .cmd_stb(cmd_stb), .si(si), .wdata(wdata),
    .rdata(rdata), .busy(busy), .sram_addr(sram_addr), .sram_dout(sram_dout),
    .sram_din(sram_din), .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  assign ctl = {busy, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe};

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic modelReset();
    mAddr = '0; mRdata = '0; mDout = '0; opK = 0; opWrite = 0; opInc = 0;
  endtask

  // Expected {busy, ce_n, oe_n, we_n, dq_oe} for the current cycle of the access in flight.
  function automatic logic [4:0] expCtl();
    bit strobe;
    if (opK == 0) return 5'b01110;
    strobe = (opK >= 2) && (opK <= W + 2);
    return {1'b1, !(opK <= W + 2), !(strobe && !opWrite), !(strobe && opWrite), opWrite};
  endfunction

  task automatic modelEdge();
    if (!reset_n) begin
      modelReset();
    end else if (opK > 0) begin
      if (!opWrite && opK == W + 2) mRdata = sram_din;
      if (opK == W + 3) begin
        if (opInc) mAddr = mAddr + 1'b1;
        opK = 0;
      end else begin
        opK++;
      end
    end else if (cmd_stb) begin
      case (cmd)
        3'd1: mAddr = {mAddr[AW-2:0], si};
        3'd6: mAddr = '0;
        3'd2, 3'd3, 3'd4, 3'd5: begin
          opK     = 1;
          opWrite = (cmd == 3'd3) || (cmd == 3'd5);
          opInc   = (cmd == 3'd4) || (cmd == 3'd5);
          if (opWrite) mDout = wdata;
        end
        default: ;
      endcase
    end
  endtask

  task automatic applyStimulus(input logic stb, input logic [2:0] c, input logic s,
                               input logic [DW-1:0] wd, input logic [DW-1:0] din);
    cmd_stb = stb; cmd = c; si = s; wdata = wd; sram_din = din;
  endtask

  task automatic advance();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic loadAddr(input logic [AW-1:0] value);
    applyStimulus(1'b1, 3'd6, 1'b0, '0, '0);
    advance();
    for (int i = AW - 1; i >= 0; i--) begin
      applyStimulus(1'b1, 3'd1, value[i], '0, '0);
      advance();
    end
    applyStimulus(1'b0, 3'd0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    applyStimulus(1'b1, 3'd3, 1'b0, 8'hFF, 8'h00);
    repeat (3) begin
      @(negedge clk);
      nChecks++;
      if (ctl !== 5'b01110 || sram_addr !== '0 || rdata !== '0 || sram_dout !== '0) begin
        nErrors++;
        $display("[TB] FAIL reset_hold: ctl=%b addr=%h rdata=%h dout=%h, required ctl=01110 and zeros",
                 ctl, sram_addr, rdata, sram_dout);
      end
      advance();
    end
    applyStimulus(1'b0, 3'd0, 1'b0, '0, '0);
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      nChecks++;
      if (ctl !== 5'b01110) begin
        nErrors++;
        $display("[TB] FAIL reset_release_idle: ctl=%b, required 01110", ctl);
      end
      advance();
    end
  endtask

  task automatic test_shift();
    for (int i = 0; i < AW; i++) begin
      applyStimulus(1'b1, 3'd1, (i % 2 == 0), '0, '0);
      advance();
      @(negedge clk);
      nChecks++;
      if (busy !== 1'b0 || sram_addr !== mAddr) begin
        nErrors++;
        $display("[TB] FAIL shift_step %0d: busy=%b addr=%h, required busy=0 addr=%h", i, busy, sram_addr, mAddr);
      end
    end
    applyStimulus(1'b0, 3'd0, 1'b0, '0, '0);
    nChecks++;
    if (sram_addr !== 21'h155555) begin
      nErrors++;
      $display("[TB] FAIL shift_pattern: addr=%h, required 155555", sram_addr);
    end
    applyStimulus(1'b1, 3'd6, 1'b0, '0, '0);
    advance();
    applyStimulus(1'b0, 3'd0, 1'b0, '0, '0);
    @(negedge clk);
    nChecks++;
    if (sram_addr !== '0 || busy !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL clr_addr: addr=%h busy=%b, required 000000 and 0", sram_addr, busy);
    end
    advance();
  endtask

  task automatic test_write();
    loadAddr(21'h000010);
    applyStimulus(1'b1, 3'd3, 1'b0, 8'hA5, '0);
    advance();
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b0, 3'd0, 1'b0, '0, '0);
      @(negedge clk);
      nChecks++;
      if (ctl !== {k <= 5, k >= 5, 1'b1, !(k >= 2 && k <= 4), k <= 5}) begin
        nErrors++;
        $display("[TB] FAIL write_ctl cycle %0d: ctl=%b, required %b", k, ctl,
                 {k <= 5, k >= 5, 1'b1, !(k >= 2 && k <= 4), k <= 5});
      end
      nChecks++;
      if (sram_dout !== 8'hA5 || sram_addr !== 21'h000010) begin
        nErrors++;
        $display("[TB] FAIL write_data cycle %0d: dout=%h addr=%h, required A5 and 000010", k, sram_dout, sram_addr);
      end
      advance();
    end
  endtask

  task automatic test_read_inc();
    loadAddr(21'h1FFFFF);
    applyStimulus(1'b1, 3'd4, 1'b0, '0, 8'h3C);
    advance();
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b0, 3'd0, 1'b0, '0, 8'h3C);
      @(negedge clk);
      nChecks++;
      if (ctl !== {k <= 5, k >= 5, !(k >= 2 && k <= 4), 1'b1, 1'b0}) begin
        nErrors++;
        $display("[TB] FAIL read_inc_ctl cycle %0d: ctl=%b, required %b", k, ctl,
                 {k <= 5, k >= 5, !(k >= 2 && k <= 4), 1'b1, 1'b0});
      end
      nChecks++;
      if (sram_addr !== ((k >= 6) ? 21'h000000 : 21'h1FFFFF)) begin
        nErrors++;
        $display("[TB] FAIL read_inc_addr cycle %0d: addr=%h, required %h", k, sram_addr,
                 (k >= 6) ? 21'h000000 : 21'h1FFFFF);
      end
      if (k >= 5) begin
        nChecks++;
        if (rdata !== 8'h3C) begin
          nErrors++;
          $display("[TB] FAIL read_inc_rdata cycle %0d: rdata=%h, required 3C", k, rdata);
        end
      end
      advance();
    end
  endtask

  task automatic test_drop_while_busy();
    loadAddr(21'h000020);
    applyStimulus(1'b1, 3'd2, 1'b0, '0, 8'h66);
    advance();
    for (int k = 1; k <= 7; k++) begin
      if (k == 3) applyStimulus(1'b1, 3'd3, 1'b0, 8'h5A, 8'h66);
      else        applyStimulus(1'b0, 3'd0, 1'b0, '0, 8'h66);
      @(negedge clk);
      nChecks++;
      if (ctl !== {k <= 5, k >= 5, !(k >= 2 && k <= 4), 1'b1, 1'b0} || sram_dout !== 8'hA5) begin
        nErrors++;
        $display("[TB] FAIL drop_busy cycle %0d: ctl=%b dout=%h, required %b and A5", k, ctl, sram_dout,
                 {k <= 5, k >= 5, !(k >= 2 && k <= 4), 1'b1, 1'b0});
      end
      if (k >= 5) begin
        nChecks++;
        if (rdata !== 8'h66) begin
          nErrors++;
          $display("[TB] FAIL drop_busy_rdata cycle %0d: rdata=%h, required 66", k, rdata);
        end
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] din;
    din = 8'($urandom);
    applyStimulus(1'b1, 3'd4, 1'b0, '0, din);
    advance();
    for (int k = 1; k <= W + 4; k++) begin
      if (k == W + 4) applyStimulus(1'b1, 3'd5, 1'b0, 8'h96, din);
      else            applyStimulus(1'b0, 3'd0, 1'b0, '0, din);
      @(negedge clk);
      nChecks++;
      if (ctl !== expCtl() || sram_addr !== mAddr || rdata !== mRdata) begin
        nErrors++;
        $display("[TB] FAIL b2b_read cycle %0d: ctl=%b addr=%h rdata=%h, required %b %h %h",
                 k, ctl, sram_addr, rdata, expCtl(), mAddr, mRdata);
      end
      advance();
    end
    applyStimulus(1'b0, 3'd0, 1'b0, '0, din);
    @(negedge clk);
    nChecks++;
    if (busy !== 1'b1 || sram_ce_n !== 1'b0 || sram_dq_oe !== 1'b1 || sram_dout !== 8'h96) begin
      nErrors++;
      $display("[TB] FAIL b2b_write_start: busy=%b ce_n=%b dq_oe=%b dout=%h, required 1 0 1 96",
               busy, sram_ce_n, sram_dq_oe, sram_dout);
    end
    repeat (W + 4) advance();
  endtask

  task automatic test_reset_mid_write();
    loadAddr(21'h000033);
    applyStimulus(1'b1, 3'd5, 1'b0, 8'hC3, '0);
    advance();
    applyStimulus(1'b0, 3'd0, 1'b0, '0, '0);
    advance();
    @(negedge clk);
    nChecks++;
    if (sram_we_n !== 1'b0 || sram_dq_oe !== 1'b1) begin
      nErrors++;
      $display("[TB] FAIL midreset_pre: we_n=%b dq_oe=%b, required 0 and 1", sram_we_n, sram_dq_oe);
    end
    #1;
    reset_n = 1'b0;
    modelReset();
    #1;
    nChecks++;
    if (ctl !== 5'b01110 || sram_addr !== '0 || sram_dout !== '0) begin
      nErrors++;
      $display("[TB] FAIL midreset_async: ctl=%b addr=%h dout=%h, required 01110 and zeros", ctl, sram_addr, sram_dout);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      nChecks++;
      if (ctl !== 5'b01110 || sram_addr !== '0) begin
        nErrors++;
        $display("[TB] FAIL midreset_release: ctl=%b addr=%h, required 01110 and 000000", ctl, sram_addr);
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom),
                    8'($urandom), 8'($urandom));
      @(negedge clk);
      nChecks++;
      if (ctl !== expCtl()) begin
        nErrors++;
        $display("[TB] FAIL rand_ctl cycle %0d: ctl=%b, required %b", n, ctl, expCtl());
      end
      nChecks++;
      if (sram_addr !== mAddr || rdata !== mRdata || sram_dout !== mDout) begin
        nErrors++;
        $display("[TB] FAIL rand_data cycle %0d: addr=%h rdata=%h dout=%h, required %h %h %h",
                 n, sram_addr, rdata, sram_dout, mAddr, mRdata, mDout);
      end
      nChecks++;
      if ((!sram_oe_n && !sram_we_n) || (!sram_oe_n && sram_dq_oe)) begin
        nErrors++;
        $display("[TB] FAIL rand_exclusion cycle %0d: oe_n=%b we_n=%b dq_oe=%b, required no overlap",
                 n, sram_oe_n, sram_we_n, sram_dq_oe);
      end
      advance();
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_shift();
    test_write();
    test_read_inc();
    test_drop_while_busy();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
